// File: rtl/uart_defs.sv
// Shared UART definitions: line-rate defaults, frame geometry and FSM states.
package uart_defs;

    localparam int unsigned CLK_FREQ_DEF = 50_000_000;
    localparam int unsigned BAUD_DEF     = 115_200;
    localparam int unsigned DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // sclk cycles per bit for a given clock/baud pair
    function automatic int unsigned bit_cnt(input int unsigned clk_freq,
                                            input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus falling-edge detect
// built from registered samples of the synchronized value.
module uart_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sclk,
    input  logic RSTn,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // synchronizer chain plus one extra stage holding the previous synced value
    always_ff @(posedge sclk or negedge RSTn) begin
        if (!RSTn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uartrecv.sv
// UART 8N1 receiver, LSB first. Validates the start bit at mid-bit, samples
// data and stop bits at bit centres, and reports each frame with a one-cycle
// done or framing-error strobe.
module uartrecv
    import uart_defs::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
    parameter int unsigned BAUD     = BAUD_DEF
) (
    input  logic       sclk,
    input  logic       RSTn,
    input  logic       RX_Pin_In,
    output logic [7:0] RX_Data,
    output logic       RX_Done_sig,
    output logic       Frame_Err,
    output logic       Busy
);

    localparam int unsigned BIT_CNT  = bit_cnt(CLK_FREQ, BAUD);
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned CW       = $clog2(BIT_CNT);
    localparam int unsigned IW       = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_sync_edge #(
        .RST_VAL(1'b1)
    ) u_sync (
        .sclk (sclk),
        .RSTn (RSTn),
        .din  (RX_Pin_In),
        .dout (rx_s),
        .fall (rx_fall)
    );

    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 err_q;
    logic                 busy_q;

    assign cnt_d = cnt_q + 1'b1;

    // receive FSM with registered data, strobes and busy flag
    always_ff @(posedge sclk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rx_fall) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_STOP: begin
                    // leave at mid-stop so a start edge right after the stop bit is seen
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (rx_s) begin
                            data_q <= shift_q;
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RX_Data     = data_q;
    assign RX_Done_sig = done_q;
    assign Frame_Err   = err_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_uartrecv.sv
// Self-checking bench for uartrecv at 50 MHz / 115200 baud.
module tb_uartrecv;

    localparam int BIT  = 434;   // 50_000_000 / 115200
    localparam int HALF = 217;

    logic       sclk = 1'b0;
    logic       RSTn;
    logic       rx_pin;
    logic [7:0] RX_Data;
    logic       RX_Done_sig;
    logic       Frame_Err;
    logic       Busy;

    uartrecv #(
        .CLK_FREQ(50_000_000),
        .BAUD    (115_200)
    ) dut (
        .sclk        (sclk),
        .RSTn        (RSTn),
        .RX_Pin_In   (rx_pin),
        .RX_Data     (RX_Data),
        .RX_Done_sig (RX_Done_sig),
        .Frame_Err   (Frame_Err),
        .Busy        (Busy)
    );

    always #10 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    // strobe / busy monitor, sampled on the inactive edge
    int   done_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
    int   busy_rise_cnt = 0;
    int   last_done_cyc = 0, last_err_cyc = 0, last_busy_rise = 0, last_busy_fall = 0;
    logic prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

    always @(negedge sclk) begin
        if (RSTn === 1'b1) begin
            if (RX_Done_sig === 1'b1) begin done_cnt++; last_done_cyc = cyc; end
            if (Frame_Err === 1'b1)   begin err_cnt++;  last_err_cyc = cyc;  end
            if (RX_Done_sig === 1'b1 && Frame_Err === 1'b1) overlap_cnt++;
            if ((RX_Done_sig === 1'b1 && prev_done) || (Frame_Err === 1'b1 && prev_err)) wide_cnt++;
            if (Busy === 1'b1 && !prev_busy) begin busy_rise_cnt++; last_busy_rise = cyc; end
            if (Busy === 1'b0 && prev_busy)  last_busy_fall = cyc;
        end
        prev_done = (RX_Done_sig === 1'b1);
        prev_err  = (Frame_Err === 1'b1);
        prev_busy = (Busy === 1'b1);
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_pin = v;
        repeat (BIT) @(negedge sclk);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic stop, output int t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0, d0, e0, lat;

        vecs[0] = '{8'h55, 1'b1, 2, 1, 0, 8'h55};
        vecs[1] = '{8'hA3, 1'b0, 2, 0, 1, 8'h55};
        vecs[2] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF};
        vecs[4] = '{8'h6B, 1'b1, 1, 1, 0, 8'h6B};

        // reset values
        RSTn   = 1'b0;
        rx_pin = 1'b1;
        #50;
        check("rst RX_Data", 32'(RX_Data), 32'h00);
        check("rst Done", 32'(RX_Done_sig), 32'h0);
        check("rst Frame_Err", 32'(Frame_Err), 32'h0);
        check("rst Busy", 32'(Busy), 32'h0);
        #50;
        RSTn = 1'b1;
        repeat (20 * BIT) @(negedge sclk);
        check("idle done count", 32'(done_cnt), 32'd0);
        check("idle err count", 32'(err_cnt), 32'd0);
        check("idle busy rises", 32'(busy_rise_cnt), 32'd0);
        check("idle RX_Data", 32'(RX_Data), 32'h00);

        // table-driven frames; checks happen at the end of each stop bit
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            tx_frame(vecs[i].data, vecs[i].stop, t0);
            check($sformatf("v%0d done pulses", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
            check($sformatf("v%0d err pulses", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("v%0d RX_Data", i), 32'(RX_Data), 32'(vecs[i].exp_data));
            lat = (vecs[i].exp_done != 0) ? (last_done_cyc - t0) : (last_err_cyc - t0);
            check_rng($sformatf("v%0d strobe latency", i), lat, 9 * BIT + HALF + 2, 9 * BIT + HALF + 5);
            check_rng($sformatf("v%0d busy fall in stop", i), last_busy_fall - (t0 + 9 * BIT), HALF, 260);
            rx_pin = 1'b1;
            repeat (vecs[i].gap_bits * BIT) @(negedge sclk);
        end

        // glitch rejection
        d0 = done_cnt;
        e0 = err_cnt;
        rx_pin = 1'b0;
        repeat (5) @(negedge sclk);
        rx_pin = 1'b1;
        repeat (BIT) @(negedge sclk);
        check("glitch busy width", 32'(last_busy_fall - last_busy_rise), 32'(HALF));
        check("glitch done pulses", 32'(done_cnt - d0), 32'd0);
        check("glitch err pulses", 32'(err_cnt - e0), 32'd0);
        check("glitch RX_Data", 32'(RX_Data), 32'h6B);
        check("glitch Busy", 32'(Busy), 32'h0);

        // break: line held low for 12 bit times gives a single framing error
        d0 = done_cnt;
        e0 = err_cnt;
        rx_pin = 1'b0;
        repeat (12 * BIT) @(negedge sclk);
        rx_pin = 1'b1;
        repeat (2 * BIT) @(negedge sclk);
        check("break err pulses", 32'(err_cnt - e0), 32'd1);
        check("break done pulses", 32'(done_cnt - d0), 32'd0);
        check("break RX_Data", 32'(RX_Data), 32'h6B);

        // reset during data bit 3 of 0x3C
        d0 = done_cnt;
        e0 = err_cnt;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_pin = 1'b1;
        repeat (BIT / 2) @(negedge sclk);
        RSTn = 1'b0;
        repeat (5) @(negedge sclk);
        check("midrst RX_Data", 32'(RX_Data), 32'h00);
        check("midrst Busy", 32'(Busy), 32'h0);
        RSTn = 1'b1;
        repeat (2 * BIT) @(negedge sclk);
        check("midrst done pulses", 32'(done_cnt - d0), 32'd0);
        check("midrst err pulses", 32'(err_cnt - e0), 32'd0);

        // transmitter-model frame after the aborted one
        d0 = done_cnt;
        e0 = err_cnt;
        tx_frame(8'hC5, 1'b1, t0);
        rx_pin = 1'b1;
        repeat (BIT) @(negedge sclk);
        check("loop done pulses", 32'(done_cnt - d0), 32'd1);
        check("loop err pulses", 32'(err_cnt - e0), 32'd0);
        check("loop RX_Data", 32'(RX_Data), 32'hC5);
        check_rng("loop strobe latency", last_done_cyc - t0, 9 * BIT + HALF + 2, 9 * BIT + HALF + 5);

        check("strobe overlap", 32'(overlap_cnt), 32'd0);
        check("strobe width", 32'(wide_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uartrecv.md
Name: uartrecv

Overview:
- UART receive path, 8N1, LSB first. It is the receiving counterpart of uartsent.
- Samples the asynchronous RX pin and validates the start bit at mid-bit. It then samples 8 data bits and the stop bit at bit centres.
- Presents each good byte with a one-cycle done strobe. A bad stop bit raises a one-cycle error strobe instead.
- Sits between the external RX pin (from the MCU) and user logic. The same CLK_FREQ/BAUD pair gives loopback compatibility with uartsent.

Parameters:
- CLK_FREQ, 50_000_000, sclk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- BIT_CNT, CLK_FREQ/BAUD (434 at the defaults), sclk cycles per bit (derived localparam).
- HALF_CNT, BIT_CNT/2 (217), cycles from the detected start edge to the start-bit centre (derived localparam).

Ports:
- sclk  input  1  system clock.
- RSTn  input  1  asynchronous reset, active low.
- RX_Pin_In  input  1  UART RX pin, asynchronous, idles high.
- RX_Data  output  8  last correctly received byte.
- RX_Done_sig  output  1  one-cycle pulse: RX_Data has just been updated.
- Frame_Err  output  1  one-cycle pulse: the stop bit sampled low, and the byte was discarded.
- Busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, sclk. RSTn is asynchronous and active low.
- Reset values: RX_Data=8'h00, RX_Done_sig=0, Frame_Err=0, Busy=0, FSM=IDLE, counters=0. Synchronizer flops reset to 1 (line idle).
- Input synchronisation:
  - Two-flop synchronizer on RX_Pin_In.
  - A falling edge is detected when the previous synced value is 1 and the current synced value is 0.
  - Edge-detect latency is 2-3 sclk after the pin transition.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge, load the cycle counter with 0 and go to START. Busy rises the same cycle.
- START:
  - Count to HALF_CNT-1, then sample.
  - Sample 0: go to DATA, with the bit index cleared and the counter cleared.
  - Sample 1: glitch. Return to IDLE with no strobe.
- DATA:
  - Every BIT_CNT cycles, sample the synced line into shift[bit_idx] (LSB first) and increment bit_idx.
  - After bit_idx reaches 7 and that bit is sampled, go to STOP.
- STOP:
  - After BIT_CNT cycles, sample the line.
  - Sample 1: RX_Data <= shift, and RX_Done_sig=1 on the next cycle.
  - Sample 0: Frame_Err=1 on the next cycle, and RX_Data holds its old value.
  - Either way, return to IDLE immediately. The FSM does not wait for the end of the stop bit, so a start edge directly after the stop bit is caught.
- Timing, with E the edge-detect cycle:
  - Start sample at E+HALF_CNT.
  - Data bit k sample at E+HALF_CNT+(k+1)*BIT_CNT.
  - Stop sample at E+HALF_CNT+9*BIT_CNT.
  - Strobe one cycle after the stop sample.
- Strobes:
  - RX_Done_sig and Frame_Err are never high together.
  - Each strobe is exactly one cycle wide.
  - There is no back-pressure: the consumer must take RX_Data within one frame time.
- Counter sizing: the counter width is clog2(BIT_CNT). The counter wraps to 0 at every sample point and never free-runs past BIT_CNT-1.
- Line behaviour while busy: a low during STOP/DATA is just data. Falling edges are ignored outside IDLE.
- Reset mid-frame: everything returns to its reset values asynchronously. The partially received byte is lost, and no strobe is produced.
- Line held low permanently (break): one Frame_Err per detected edge. A new edge needs the line to return high first.

Decomposition:
- Shared package uart_defs, also used by uartsent:
  - CLK_FREQ and BAUD defaults.
  - Derived BIT_CNT.
  - DATA_BITS=8.
  - State encodings for IDLE/START/DATA/STOP.
- One sub-module: uart_sync_edge (two-flop synchronizer plus registered falling-edge detect).
  - Ports: sclk, RSTn, din, dout, fall.
  - Reset value parameterisable, defaulting to 1.

Test Plan:
- Reset values:
  - Stimulus: RSTn=0 for 100 ns, pin high.
  - Required: RX_Data=8'h00, RX_Done_sig=0, Frame_Err=0, Busy=0. After release, nothing changes for 20 bit times of idle.
- Single frame:
  - Stimulus: drive frame 0x55 at 115200 (8680 ns/bit).
  - Required: exactly one RX_Done_sig pulse, within ±1 bit time of 9.5 bit times after the start edge. RX_Data=8'h55. Frame_Err stays 0. Busy falls within 0.5-0.6 bit times into the stop bit.
- Glitch rejection:
  - Stimulus: pin low for 100 ns (5 clocks), then high.
  - Required: Busy returns to 0 at HALF_CNT after the edge. No strobes. RX_Data unchanged.
- Framing error:
  - Stimulus: after receiving 0x55, send 0xA3 with the stop bit driven 0.
  - Required: one Frame_Err pulse, no RX_Done_sig, RX_Data stays 8'h55.
- Back-to-back frames:
  - Stimulus: 0x00 then 0xFF, with the second start bit immediately after the first stop bit.
  - Required: two RX_Done_sig pulses, with RX_Data=8'h00 then 8'hFF.
- Reset mid-frame, then loopback:
  - Stimulus: assert RSTn low during data bit 3 of 0x3C. Then release, connect uartsent TX_Pin_Out to RX_Pin_In, and pulse Do_sig.
  - Required: no strobe from the aborted frame. The uartsent byte is received correctly with one RX_Done_sig.
